// File: rtl/priority_encoder_pipelined.sv
// rtl/priority_encoder_pipelined.sv - pipelined radix-SPLIT priority encoder with valid/ready handshake
module priority_encoder_pipelined #(
  parameter int WIDTH       = 32,
  parameter int SPLIT       = 4,
  parameter int ROUND_ROBIN = 0,
  localparam int WIDTH_LOG  = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_vld,
  output logic                 s_rdy,
  input  logic [WIDTH-1:0]     dec_vld,
  output logic                 m_vld,
  input  logic                 m_rdy,
  output logic [WIDTH_LOG-1:0] enc_idx,
  output logic                 enc_vld
);

  localparam int SPLIT_LOG  = $clog2(SPLIT);
  localparam int LEVELS_RAW = (WIDTH_LOG + SPLIT_LOG - 1) / SPLIT_LOG;
  localparam int LEVELS     = (LEVELS_RAW < 1) ? 1 : LEVELS_RAW;
  localparam int PAD        = SPLIT ** LEVELS;
  // Candidate 0 is the raw vector; in round-robin mode candidate 1 is the pointer-masked vector.
  localparam int NC         = (ROUND_ROBIN != 0) ? 2 : 1;

  logic [PAD-1:0]    dec_pad;
  logic [PAD-1:0]    cand [NC];
  logic [LEVELS-1:0] stg_vld_q;
  logic [LEVELS-1:0] stg_rdy;
  logic [LEVELS-1:0] stg_in_vld;
  logic              accept;

  assign dec_pad = PAD'(dec_vld);
  assign accept  = s_vld && s_rdy;
  assign m_vld   = stg_vld_q[LEVELS-1];

  // Ready chain from the output back: a stage may load when empty or when it is draining.
  always_comb begin : p_rdy
    logic nxt;
    stg_rdy = '0;
    nxt     = m_rdy;
    for (int k = LEVELS - 1; k >= 0; k--) begin
      stg_rdy[k] = !stg_vld_q[k] || nxt;
      nxt        = stg_rdy[k];
    end
  end

  // Valid bit arriving at each stage: the accept for the first, the previous stage otherwise.
  always_comb begin
    stg_in_vld    = '0;
    stg_in_vld[0] = accept;
    for (int k = 1; k < LEVELS; k++) begin
      stg_in_vld[k] = stg_vld_q[k-1];
    end
  end

  // Stage-valid bits move forward whenever the stage is ready; bubbles fill in behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld_q <= '0;
    end else begin
      for (int k = 0; k < LEVELS; k++) begin
        if (stg_rdy[k]) stg_vld_q[k] <= stg_in_vld[k];
      end
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int NODES   = PAD / (SPLIT ** (k + 1));
    localparam int IW_FULL = (k + 1) * SPLIT_LOG;
    // A winning index is always below WIDTH, so narrowing to WIDTH_LOG never loses information.
    localparam int IW      = (IW_FULL < WIDTH_LOG) ? IW_FULL : WIDTH_LOG;
    localparam int SPAN    = SPLIT ** k;

    logic [NODES-1:0] nv_d [NC];
    logic [NODES-1:0] nv_q [NC];
    logic [IW-1:0]    ni_d [NC][NODES];
    logic [IW-1:0]    ni_q [NC][NODES];

    if (k == 0) begin : g_leaf
      // Leaf: OR of each SPLIT-bit group and the position of its lowest set bit.
      always_comb begin
        for (int c = 0; c < NC; c++) begin
          for (int n = 0; n < NODES; n++) begin
            nv_d[c][n] = 1'b0;
            ni_d[c][n] = '0;
            for (int b = SPLIT - 1; b >= 0; b--) begin
              if (cand[c][n*SPLIT+b]) begin
                nv_d[c][n] = 1'b1;
                ni_d[c][n] = IW'(b);
              end
            end
          end
        end
      end
    end else begin : g_node
      // Inner node: lowest-numbered valid child wins; its offset is prepended to the child index.
      always_comb begin
        for (int c = 0; c < NC; c++) begin
          for (int n = 0; n < NODES; n++) begin
            nv_d[c][n] = 1'b0;
            ni_d[c][n] = '0;
            for (int ch = SPLIT - 1; ch >= 0; ch--) begin
              if (g_lvl[k-1].nv_q[c][n*SPLIT+ch]) begin
                nv_d[c][n] = 1'b1;
                ni_d[c][n] = IW'(ch * SPAN + 32'(g_lvl[k-1].ni_q[c][n*SPLIT+ch]));
              end
            end
          end
        end
      end
    end

    // Level result register, loaded when valid data arrives at a ready stage.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int c = 0; c < NC; c++) begin
          nv_q[c] <= '0;
          for (int n = 0; n < NODES; n++) begin
            ni_q[c][n] <= '0;
          end
        end
      end else if (stg_rdy[k] && stg_in_vld[k]) begin
        nv_q <= nv_d;
        ni_q <= ni_d;
      end
    end
  end

  assign enc_vld = g_lvl[LEVELS-1].nv_q[0][0];

  if (ROUND_ROBIN != 0) begin : g_rr
    logic [WIDTH_LOG-1:0] ptr_q;
    logic [WIDTH_LOG-1:0] ptr_d;
    logic [WIDTH-1:0]     rr_mask;

    assign rr_mask = {WIDTH{1'b1}} << ptr_q;

    // Both the raw and the masked vectors enter the tree side by side.
    always_comb begin
      cand[0]    = dec_pad;
      cand[NC-1] = dec_pad & PAD'(rr_mask);
    end

    // Masked result wins when it found anything, otherwise fall back to the raw result.
    assign enc_idx = g_lvl[LEVELS-1].nv_q[NC-1][0] ? g_lvl[LEVELS-1].ni_q[NC-1][0]
                                                   : g_lvl[LEVELS-1].ni_q[0][0];

    // One request in flight so the next one sees the pointer left by this result.
    assign s_rdy = ~|stg_vld_q;

    // Pointer moves just past the granted index on each non-empty output transfer.
    always_comb begin
      ptr_d = ptr_q;
      if (m_vld && m_rdy && enc_vld) begin
        ptr_d = (enc_idx == WIDTH_LOG'(WIDTH - 1)) ? '0 : enc_idx + WIDTH_LOG'(1);
      end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
    end
  end else begin : g_fixed
    // Fixed priority: only the raw vector is encoded.
    always_comb begin
      cand[0] = dec_pad;
    end

    assign enc_idx = g_lvl[LEVELS-1].ni_q[0][0];
    assign s_rdy   = stg_rdy[0];
  end

endmodule
